ccss_multicore_arbiter: RTL and testbench

Parametrised multi-core launch and shared-data-memory controller for the CCSS matrix processor.
- Sequences reset, run and completion of NUM_CORES identical single-core datapaths.
- Arbitrates their data-memory accesses round-robin onto one DRAM port.
- Raises a completion flag once every core has signalled end of process.
- Sits between the per-core datapaths and the single data memory.

---
 rtl/ccss_multicore_arbiter_pkg.sv | 26 ++
 rtl/ccss_multicore_arbiter_if.sv | 30 +++
 rtl/ccss_multicore_arbiter_rr_arbiter.sv | 50 +++++
 rtl/ccss_multicore_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_ccss_multicore_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ccss_multicore_arbiter_pkg.sv
// Shared types and helpers for the CCSS multi-core launch / memory arbiter.
// Holds the controller state encoding, the core-count ceiling and the
// pointer-width helper used by the top and the round-robin arbiter.
package ccss_arb_pkg;

    localparam int MAX_CORES = 8;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RESET_CORES = 2'd1,
        RUN         = 2'd2,
        DONE        = 2'd3
    } arb_state_e;

    // Width of an index into 'value' entries; never below one bit so that a
    // single-core build still has a legal (constant-zero) pointer.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd1;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ccss_multicore_arbiter_if.sv
// Core-side request bus plus the single DRAM port of the CCSS arbiter.
// 'master' is the core/memory side that issues requests and returns mem_q;
// 'slave' is the arbiter that grants and drives the memory port.
interface ccss_multicore_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16
);
    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES-1:0]        core_we;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES*DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]        core_gnt;
    logic [NUM_CORES-1:0]        core_rvalid;
    logic [DATA_W-1:0]           core_rdata;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_wren;
    logic [DATA_W-1:0]           mem_q;

    modport master (
        output core_req, core_we, core_addr, core_wdata, mem_q,
        input  core_gnt, core_rvalid, core_rdata, mem_addr, mem_wdata, mem_wren
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, mem_q,
        output core_gnt, core_rvalid, core_rdata, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/ccss_multicore_arbiter_rr_arbiter.sv
// Purely combinational rotating-priority arbiter. The search starts at 'ptr'
// and walks upward with wrap; the first unmasked requester wins. The pointer
// register itself is owned by the instantiating block.
module rr_arbiter
    import ccss_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          valid
);

    logic [N-1:0]  eligible_s;
    logic [PW-1:0] cand_s;

    // Requests that may compete this cycle: enabled and not masked off.
    always_comb begin
        eligible_s = '0;
        if (en) begin
            eligible_s = req & ~mask;
        end else begin
            eligible_s = '0;
        end
    end

    // Rotating first-match search starting at the pointer.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        valid  = 1'b0;
        cand_s = '0;
        for (int i = 0; i < N; i++) begin
            cand_s = PW'((int'(ptr) + i) % N);
            if (!valid && eligible_s[cand_s]) begin
                valid       = 1'b1;
                idx         = cand_s;
                gnt[cand_s] = 1'b1;
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/ccss_multicore_arbiter.sv
// CCSS multi-core launch and shared data-memory controller.
// Sequences reset/run/completion of NUM_CORES datapaths and arbitrates their
// memory traffic round-robin onto one DRAM port (read data one cycle later).
// Optional build macro CCSS_STALL_CNT_EN adds per-core saturating stall
// counters; without it stall_cnt is tied to zero.
module ccss_multicore_arbiter
    import ccss_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [NUM_CORES-1:0]    core_rst,
    output logic [NUM_CORES-1:0]    core_run,
    input  logic [NUM_CORES-1:0]    core_end,
    ccss_multicore_arbiter_if.slave bus,
    output logic                    busy,
    output logic                    all_done,
    output logic [CNT_W-1:0]        run_cycles,
    output logic [NUM_CORES*16-1:0] stall_cnt
);

    localparam int PW = clog2(NUM_CORES);

    arb_state_e           state_r;
    arb_state_e           state_s;
    logic [NUM_CORES-1:0] done_mask_r;
    logic [PW-1:0]        ptr_r;
    logic [PW-1:0]        ptr_next_s;
    logic [NUM_CORES-1:0] rd_pending_r;
    logic [ADDR_W-1:0]    last_addr_r;
    logic [DATA_W-1:0]    last_wdata_r;
    logic [CNT_W-1:0]     run_cycles_r;
    logic [NUM_CORES-1:0] gnt_s;
    logic [PW-1:0]        gnt_idx_s;
    logic                 gnt_valid_s;
    logic                 arb_en_s;
    logic [ADDR_W-1:0]    win_addr_s;
    logic [DATA_W-1:0]    win_wdata_s;
    logic                 win_we_s;

    // Next-state logic of the launch/run/done sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RESET_CORES;
                else       state_s = IDLE;
            end
            RESET_CORES: state_s = RUN;
            RUN: begin
                if (&(done_mask_r | core_end)) state_s = DONE;
                else                           state_s = RUN;
            end
            DONE: begin
                if (start) state_s = RESET_CORES;
                else       state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_s;
    end

    // Sticky per-core completion mask and saturating run-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_mask_r  <= '0;
            run_cycles_r <= '0;
        end else if (state_r == RESET_CORES) begin
            done_mask_r  <= '0;
            run_cycles_r <= '0;
        end else if (state_r == RUN) begin
            done_mask_r <= done_mask_r | core_end;
            if (run_cycles_r != {CNT_W{1'b1}}) begin
                run_cycles_r <= run_cycles_r + CNT_W'(1);
            end
        end
    end

    // Status and per-core control outputs, all decoded from registered state.
    always_comb begin
        core_rst   = '0;
        core_run   = '0;
        busy       = 1'b0;
        all_done   = 1'b0;
        run_cycles = run_cycles_r;
        arb_en_s   = 1'b0;
        case (state_r)
            IDLE: busy = 1'b0;
            RESET_CORES: begin
                core_rst = '1;
                busy     = 1'b1;
            end
            RUN: begin
                core_run = ~done_mask_r;
                busy     = 1'b1;
                arb_en_s = 1'b1;
            end
            DONE: all_done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    rr_arbiter #(
        .N  (NUM_CORES),
        .PW (PW)
    ) u_rr_arbiter (
        .req   (bus.core_req),
        .mask  (done_mask_r),
        .ptr   (ptr_r),
        .en    (arb_en_s),
        .gnt   (gnt_s),
        .idx   (gnt_idx_s),
        .valid (gnt_valid_s)
    );

    // Winner's address/data/direction and the pointer value after it.
    always_comb begin
        win_addr_s  = bus.core_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
        win_wdata_s = bus.core_wdata[int'(gnt_idx_s)*DATA_W +: DATA_W];
        win_we_s    = bus.core_we[gnt_idx_s];
        ptr_next_s  = ptr_r;
        if (gnt_idx_s == PW'(NUM_CORES - 1)) ptr_next_s = '0;
        else                                 ptr_next_s = gnt_idx_s + PW'(1);
    end

    // Pointer, held memory-port values and the one-cycle read return tracker.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r        <= '0;
            last_addr_r  <= '0;
            last_wdata_r <= '0;
            rd_pending_r <= '0;
        end else begin
            if (gnt_valid_s) begin
                ptr_r        <= ptr_next_s;
                last_addr_r  <= win_addr_s;
                last_wdata_r <= win_wdata_s;
            end
            if (gnt_valid_s && !win_we_s) rd_pending_r <= gnt_s;
            else                          rd_pending_r <= '0;
        end
    end

    // Memory port and core-side return path; address/data hold when idle.
    always_comb begin
        bus.core_gnt    = gnt_s;
        bus.core_rvalid = rd_pending_r;
        bus.core_rdata  = '0;
        bus.mem_addr    = last_addr_r;
        bus.mem_wdata   = last_wdata_r;
        bus.mem_wren    = 1'b0;
        if (gnt_valid_s) begin
            bus.mem_addr  = win_addr_s;
            bus.mem_wdata = win_wdata_s;
            bus.mem_wren  = win_we_s;
        end else begin
            bus.mem_wren  = 1'b0;
        end
        if (|rd_pending_r) bus.core_rdata = bus.mem_q;
        else               bus.core_rdata = '0;
    end

`ifdef CCSS_STALL_CNT_EN
    logic [15:0] stall_r [NUM_CORES];

    // Count RUN cycles in which a core waits on an ungranted request.
    always_ff @(posedge clk) begin
        if (!rst || state_r == RESET_CORES) begin
            for (int i = 0; i < NUM_CORES; i++) stall_r[i] <= 16'h0000;
        end else if (state_r == RUN) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (bus.core_req[i] && !gnt_s[i] && stall_r[i] != 16'hFFFF) begin
                    stall_r[i] <= stall_r[i] + 16'h0001;
                end
            end
        end
    end

    // Pack the counters onto the flat output bus.
    always_comb begin
        stall_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) stall_cnt[i*16 +: 16] = stall_r[i];
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ccss_multicore_arbiter.sv
// Directed, table-driven bench for ccss_multicore_arbiter (NUM_CORES=4).
// Each table row is one clock cycle: inputs plus the outputs expected during
// that cycle. Hand sequences cover reset mid-read, relaunch and stall counts.
module tb_ccss_multicore_arbiter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  core_rst;
    logic [3:0]  core_run;
    logic [3:0]  core_end;
    logic        busy;
    logic        all_done;
    logic [31:0] run_cycles;
    logic [63:0] stall_cnt;

    int total;
    int bad;

    ccss_multicore_arbiter_if #(.NUM_CORES(4), .DATA_W(16), .ADDR_W(16)) bus();

    ccss_multicore_arbiter #(
        .NUM_CORES (4),
        .DATA_W    (16),
        .ADDR_W    (16),
        .CNT_W     (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .core_rst   (core_rst),
        .core_run   (core_run),
        .core_end   (core_end),
        .bus        (bus),
        .busy       (busy),
        .all_done   (all_done),
        .run_cycles (run_cycles),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRAM model: data for an address appears one cycle later as address+1.
    always @(posedge clk) bus.mem_q <= bus.mem_addr + 16'h0001;

    typedef struct {
        logic        st;
        logic [3:0]  ce, rq, we;
        logic [15:0] a2;
        int          reps;
        logic [3:0]  e_rst, e_run, e_gnt, e_rv;
        logic [15:0] e_rd, e_addr;
        logic        e_wren, e_busy, e_done;
        int          e_rc;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t v(logic st, logic [3:0] ce, logic [3:0] rq, logic [3:0] we,
                               logic [15:0] a2, int reps, logic [3:0] e_rst, logic [3:0] e_run,
                               logic [3:0] e_gnt, logic [3:0] e_rv, logic [15:0] e_rd,
                               logic [15:0] e_addr, logic e_wren, logic e_busy, logic e_done,
                               int e_rc);
        vec_t r;
        r.st = st; r.ce = ce; r.rq = rq; r.we = we; r.a2 = a2; r.reps = reps;
        r.e_rst = e_rst; r.e_run = e_run; r.e_gnt = e_gnt; r.e_rv = e_rv;
        r.e_rd = e_rd; r.e_addr = e_addr; r.e_wren = e_wren; r.e_busy = e_busy;
        r.e_done = e_done; r.e_rc = e_rc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [3:0] ce, input logic [3:0] rq,
                         input logic [3:0] we, input logic [15:0] a2);
        start          = st;
        core_end       = ce;
        bus.core_req   = rq;
        bus.core_we    = we;
        bus.core_addr  = {16'h0040, a2, 16'h0020, 16'h0010};
        bus.core_wdata = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 16'h0030);

        //       st ce   rq   we   a2      rp e_rst e_run e_gnt e_rv e_rd     e_addr   wr bs dn rc
        tbl[0]  = v(1, 4'h0, 4'h0, 4'h0, 16'h0030, 1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[1]  = v(0, 4'h0, 4'hF, 4'h0, 16'h0030, 1, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 0, 1, 0, -1);
        tbl[2]  = v(0, 4'h0, 4'hF, 4'h0, 16'h0030, 1, 4'h0, 4'hF, 4'h1, 4'h0, 16'h0000, 16'h0010, 0, 1, 0, 0);
        tbl[3]  = v(0, 4'h0, 4'hF, 4'h0, 16'h0030, 1, 4'h0, 4'hF, 4'h2, 4'h1, 16'h0011, 16'h0020, 0, 1, 0, 1);
        tbl[4]  = v(0, 4'h0, 4'hF, 4'h0, 16'h0030, 1, 4'h0, 4'hF, 4'h4, 4'h2, 16'h0021, 16'h0030, 0, 1, 0, -1);
        tbl[5]  = v(0, 4'h0, 4'hF, 4'h0, 16'h0030, 1, 4'h0, 4'hF, 4'h8, 4'h4, 16'h0031, 16'h0040, 0, 1, 0, -1);
        tbl[6]  = v(0, 4'h0, 4'hF, 4'h0, 16'h0030, 1, 4'h0, 4'hF, 4'h1, 4'h8, 16'h0041, 16'h0010, 0, 1, 0, -1);
        tbl[7]  = v(0, 4'h0, 4'h0, 4'h0, 16'h0030, 1, 4'h0, 4'hF, 4'h0, 4'h1, 16'h0011, 16'h0010, 0, 1, 0, -1);
        tbl[8]  = v(0, 4'h0, 4'h4, 4'h4, 16'h0005, 1, 4'h0, 4'hF, 4'h4, 4'h0, 16'h0000, 16'h0005, 1, 1, 0, -1);
        tbl[9]  = v(0, 4'h0, 4'h0, 4'h0, 16'h0005, 1, 4'h0, 4'hF, 4'h0, 4'h0, 16'h0000, 16'h0005, 0, 1, 0, -1);
        tbl[10] = v(0, 4'h0, 4'h3, 4'h0, 16'h0030, 1, 4'h0, 4'hF, 4'h1, 4'h0, 16'h0000, 16'h0010, 0, 1, 0, -1);
        tbl[11] = v(0, 4'h0, 4'h3, 4'h0, 16'h0030, 1, 4'h0, 4'hF, 4'h2, 4'h1, 16'h0011, 16'h0020, 0, 1, 0, -1);
        tbl[12] = v(0, 4'h8, 4'h9, 4'h0, 16'h0030, 1, 4'h0, 4'hF, 4'h8, 4'h2, 16'h0021, 16'h0040, 0, 1, 0, 10);
        tbl[13] = v(0, 4'h0, 4'h8, 4'h0, 16'h0030, 1, 4'h0, 4'h7, 4'h0, 4'h8, 16'h0041, 16'h0040, 0, 1, 0, -1);
        tbl[14] = v(0, 4'h0, 4'h0, 4'h0, 16'h0030, 3, 4'h0, 4'h7, 4'h0, 4'h0, 16'h0000, 16'h0040, 0, 1, 0, -1);
        tbl[15] = v(0, 4'h1, 4'h0, 4'h0, 16'h0030, 1, 4'h0, 4'h7, 4'h0, 4'h0, 16'h0000, 16'h0040, 0, 1, 0, 15);
        tbl[16] = v(1, 4'h0, 4'h1, 4'h0, 16'h0030, 1, 4'h0, 4'h6, 4'h0, 4'h0, 16'h0000, 16'h0040, 0, 1, 0, -1);
        tbl[17] = v(0, 4'h0, 4'h0, 4'h0, 16'h0030, 3, 4'h0, 4'h6, 4'h0, 4'h0, 16'h0000, 16'h0040, 0, 1, 0, -1);
        tbl[18] = v(0, 4'h4, 4'h0, 4'h0, 16'h0030, 1, 4'h0, 4'h6, 4'h0, 4'h0, 16'h0000, 16'h0040, 0, 1, 0, 20);
        tbl[19] = v(0, 4'h1, 4'h0, 4'h0, 16'h0030, 9, 4'h0, 4'h2, 4'h0, 4'h0, 16'h0000, 16'h0040, 0, 1, 0, -1);
        tbl[20] = v(0, 4'h2, 4'h2, 4'h0, 16'h0030, 1, 4'h0, 4'h2, 4'h2, 4'h0, 16'h0000, 16'h0020, 0, 1, 0, 30);
        tbl[21] = v(0, 4'hF, 4'hF, 4'h0, 16'h0030, 1, 4'h0, 4'h0, 4'h0, 4'h2, 16'h0021, 16'h0020, 0, 0, 1, 31);
        tbl[22] = v(0, 4'h0, 4'h0, 4'h0, 16'h0030, 2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0020, 0, 0, 1, 31);

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst core_run", 32'(core_run), 32'h0);
        chk("rst core_rst", 32'(core_rst), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst all_done", 32'(all_done), 32'h0);
        chk("rst rvalid", 32'(bus.core_rvalid), 32'h0);
        chk("rst mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst mem_wren", 32'(bus.mem_wren), 32'h0);
        chk("rst run_cycles", run_cycles, 32'h0);
        chk("rst stall_cnt", 32'(stall_cnt[31:0]), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Launch, round-robin reads, write, staggered completion, DONE.
        for (int r = 0; r < 23; r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                drive(tbl[r].st, tbl[r].ce, tbl[r].rq, tbl[r].we, tbl[r].a2);
                #1;
                chk($sformatf("row%0d core_rst", r), 32'(core_rst), 32'(tbl[r].e_rst));
                chk($sformatf("row%0d core_run", r), 32'(core_run), 32'(tbl[r].e_run));
                chk($sformatf("row%0d gnt", r), 32'(bus.core_gnt), 32'(tbl[r].e_gnt));
                chk($sformatf("row%0d rvalid", r), 32'(bus.core_rvalid), 32'(tbl[r].e_rv));
                chk($sformatf("row%0d mem_addr", r), 32'(bus.mem_addr), 32'(tbl[r].e_addr));
                chk($sformatf("row%0d mem_wren", r), 32'(bus.mem_wren), 32'(tbl[r].e_wren));
                chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].e_busy));
                chk($sformatf("row%0d all_done", r), 32'(all_done), 32'(tbl[r].e_done));
                if (tbl[r].e_rv != 4'h0)
                    chk($sformatf("row%0d rdata", r), 32'(bus.core_rdata), 32'(tbl[r].e_rd));
                if (tbl[r].e_wren)
                    chk($sformatf("row%0d mem_wdata", r), 32'(bus.mem_wdata), 32'h0000BEEF);
                if (tbl[r].e_rc >= 0 && k == 0)
                    chk($sformatf("row%0d run_cycles", r), run_cycles, 32'(tbl[r].e_rc));
                @(negedge clk);
            end
        end

        // Relaunch from DONE, then reset while a read is outstanding.
        drive(1'b1, 4'h0, 4'h0, 4'h0, 16'h0030);
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 16'h0030);
        #1;
        chk("relaunch core_rst", 32'(core_rst), 32'hF);
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h2, 4'h0, 16'h0030);
        rst = 1'b0;
        #1;
        chk("relaunch run_cycles", run_cycles, 32'h0);
        chk("midrd gnt", 32'(bus.core_gnt), 32'h2);
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 16'h0030);
        #1;
        chk("midrd rvalid", 32'(bus.core_rvalid), 32'h0);
        chk("midrd busy", 32'(busy), 32'h0);
        chk("midrd core_run", 32'(core_run), 32'h0);
        chk("midrd mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("midrd all_done", 32'(all_done), 32'h0);
        rst = 1'b1;
        drive(1'b1, 4'h0, 4'h0, 4'h0, 16'h0030);
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 16'h0030);
        #1;
        chk("post-rst core_rst", 32'(core_rst), 32'hF);
        @(negedge clk);
        // Pointer restarted at 0, so core 1 beats core 3.
        drive(1'b0, 4'h0, 4'hA, 4'h0, 16'h0030);
        #1;
        chk("post-rst gnt", 32'(bus.core_gnt), 32'h2);
        chk("post-rst core_run", 32'(core_run), 32'hF);
        @(negedge clk);

        // Cores 0 and 1 contend for ten cycles; grants alternate starting at 0.
        for (int j = 0; j < 10; j++) begin
            drive(1'b0, 4'h0, 4'h3, 4'h0, 16'h0030);
            #1;
            chk($sformatf("contend%0d gnt", j), 32'(bus.core_gnt), (j % 2 == 0) ? 32'h1 : 32'h2);
            @(negedge clk);
        end
        drive(1'b0, 4'h0, 4'h0, 4'h0, 16'h0030);
        #1;
`ifdef CCSS_STALL_CNT_EN
        chk("stall_cnt0", 32'(stall_cnt[15:0]), 32'd5);
        chk("stall_cnt1", 32'(stall_cnt[31:16]), 32'd5);
        chk("stall_cnt2", 32'(stall_cnt[47:32]), 32'd0);
        chk("stall_cnt3", 32'(stall_cnt[63:48]), 32'd1);
`else
        chk("stall_cnt lo", 32'(stall_cnt[31:0]), 32'h0);
        chk("stall_cnt hi", 32'(stall_cnt[63:32]), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
